// File: rtl/ad9371_pkg.sv
// Shared widths and FIFO entry layout for the AD9371 receive channel packer.
package ad9371_pkg;

  localparam int unsigned LANE_W    = 16;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned WORD_W    = LANE_W * NUM_CH;
  localparam int unsigned ACC_LANES = 7;
  localparam int unsigned CNT_W     = 3;

  typedef struct packed {
    logic              sync;
    logic [WORD_W-1:0] data;
  } pack_entry_t;

endpackage

// File: rtl/ad9371_rx_cpack_fifo.sv
// Synchronous output FIFO of packed words with their sync flags; head is the read port.
module ad9371_rx_cpack_fifo
  import ad9371_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr,
  input  pack_entry_t wr_entry,
  input  logic        rd,
  output pack_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pack_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          wr_en;
  logic          rd_en;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign rd_en = rd && !empty;
  assign wr_en = wr && (!full || rd_en);
  assign head  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (wr_en && !rd_en) begin
      count_next = count + CW'(1);
    end else if (!wr_en && rd_en) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/ad9371_rx_cpack.sv
// Packs the enabled 16-bit ADC channels into dense 64-bit words and queues them
// in a small FIFO, flagging the first word after reset or an enable change.
module ad9371_rx_cpack
  import ad9371_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              adc_clk,
  input  logic              adc_rstn,
  input  logic [NUM_CH-1:0] adc_enable,
  input  logic              adc_valid,
  input  logic [WORD_W-1:0] adc_data,
  output logic              adc_dovf,
  output logic              pack_valid,
  output logic [WORD_W-1:0] pack_data,
  output logic              pack_sync,
  input  logic              pack_ready
);

  logic [NUM_CH-1:0]                 en_q;
  logic [ACC_LANES-1:0][LANE_W-1:0]  acc;
  logic [ACC_LANES-1:0][LANE_W-1:0]  acc_next;
  logic [CNT_W-1:0]                  cnt;
  logic [CNT_W-1:0]                  fill;
  logic                              sync_armed;
  logic                              sync_next;
  logic                              eff_sync;
  logic                              en_change;
  logic                              strobe;
  logic                              word_wr;
  logic [WORD_W-1:0]                 word;
  logic                              word_taken;
  logic                              dovf_next;
  logic                              fifo_rd;
  logic                              fifo_full;
  logic                              fifo_empty;
  pack_entry_t                       fifo_head;

  assign en_change = (adc_enable != en_q);
  assign strobe    = adc_valid && (adc_enable != '0);
  assign eff_sync  = sync_armed || en_change;
  assign fifo_rd   = pack_ready && !fifo_empty;

  // Lane accumulator: a mask change restarts from an empty accumulator before
  // the current strobe is appended with the new mask.
  always_comb begin
    acc_next = en_change ? '0 : acc;
    fill     = en_change ? '0 : cnt;
    word_wr  = 1'b0;
    word     = '0;
    if (strobe) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (adc_enable[ch]) begin
          acc_next[fill] = adc_data[ch*LANE_W +: LANE_W];
          fill           = fill + CNT_W'(1);
        end
      end
      if (fill >= CNT_W'(NUM_CH)) begin
        word_wr  = 1'b1;
        word     = acc_next[NUM_CH-1:0];
        acc_next = acc_next >> WORD_W;
        fill     = fill - CNT_W'(NUM_CH);
      end
    end
  end

  // Sync stays armed until a word carrying it actually lands in the FIFO.
  always_comb begin
    word_taken = word_wr && (!fifo_full || fifo_rd);
    dovf_next  = word_wr && fifo_full && !fifo_rd;
    sync_next  = word_taken ? 1'b0 : eff_sync;
  end

  always_ff @(posedge adc_clk) begin
    if (!adc_rstn) begin
      en_q       <= '0;
      acc        <= '0;
      cnt        <= '0;
      sync_armed <= 1'b1;
      adc_dovf   <= 1'b0;
    end else begin
      en_q       <= adc_enable;
      acc        <= acc_next;
      cnt        <= fill;
      sync_armed <= sync_next;
      adc_dovf   <= dovf_next;
    end
  end

  ad9371_rx_cpack_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (adc_clk),
    .rstn     (adc_rstn),
    .wr       (word_wr),
    .wr_entry ('{sync: eff_sync, data: word}),
    .rd       (fifo_rd),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign pack_valid = !fifo_empty;
  assign pack_data  = fifo_head.data;
  assign pack_sync  = fifo_head.sync;

endmodule

// File: doc/ad9371_rx_cpack.md
AD9371_RX_CPACK -- requirements
Module: ad9371_rx_cpack

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, min 2), output FIFO entries.
REQ-002 SHALL have port adc_clk, input, 1, sole clock; all logic rising-edge.
REQ-003 SHALL have port adc_rstn, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port adc_enable, input, 4, channel enables [i0,q0,i1,q1] = bits [0..3].
REQ-005 SHALL have port adc_valid, input, 1, sample strobe covering all four channels.
REQ-006 SHALL have port adc_data, input, 64, channel n occupies bits [16n+15:16n].
REQ-007 SHALL have port adc_dovf, output, 1, overflow pulse returned to the rx core.
REQ-008 SHALL have port pack_valid, output, 1, FIFO head valid.
REQ-009 SHALL have port pack_data, output, 64, packed word at FIFO head.
REQ-010 SHALL have port pack_sync, output, 1, head word is the first word after an enable change or reset.
REQ-011 SHALL have port pack_ready, input, 1, consumer accept.

Function
REQ-012 SHALL compute N = popcount(adc_enable), 0..4.
REQ-013 SHALL, on each adc_valid with N>0, append the enabled channels' 16-bit samples to a lane accumulator in ascending channel order (lowest enabled channel into the lowest free lane).
REQ-014 SHALL hold up to 7 lanes in the accumulator (4 full + 3 carry), tracked by a 3-bit lane count.
REQ-015 SHALL, on the edge where the lane count reaches >=4, write lanes 0..3 to the FIFO, shift remaining lanes down, and subtract 4 from the count; carry is preserved across words.
REQ-016 SHALL show the written word at pack_valid/pack_data in the cycle after the completing strobe when the FIFO was empty (1-cycle latency).
REQ-017 SHALL, for N=0, ignore adc_valid and write nothing.
REQ-018 SHALL register adc_enable; any change discards partial accumulator lanes (count := 0), arms sync, and the strobe in that same cycle is packed using the new mask into the cleared accumulator.
REQ-019 SHALL set the sync flag of the next FIFO word written after an armed sync, then disarm.
REQ-020 SHALL transfer a word when pack_valid && pack_ready; the head holds stable otherwise.
REQ-021 SHALL, on full FIFO with a write and pack_ready high in the same cycle, accept both (no overflow).
REQ-022 SHALL, on full FIFO with a write and no read, drop the new word, pulse adc_dovf high for exactly one cycle, and keep sync armed if the dropped word carried it.
REQ-023 SHALL, with an empty FIFO, write and read in the same cycle only for the existing head; a new word is never bypassed to the output.

Reset
REQ-024 SHALL, while adc_rstn=0 at an edge, clear the FIFO pointers, lane count, accumulator, and enable register, and arm sync.
REQ-025 SHALL drive pack_valid=0, pack_sync=0, pack_data=0, adc_dovf=0 from the first edge of reset.
REQ-026 SHALL discard in-flight words when reset is asserted mid-operation; the first post-reset word carries pack_sync=1.

Structure
REQ-027 SHALL take lane width (16), channel count (4), and word width (64) constants from shared package ad9371_pkg.
REQ-028 SHALL implement the output FIFO as sub-module ad9371_rx_cpack_fifo (synchronous, 65-bit entries: data+sync, full/empty flags).

Verification
REQ-029 Mask 4'b1111, 3 strobes of 0x0004_0003_0002_0001 + k -> 3 words equal to inputs, each at 1-cycle latency; first word sync=1.
REQ-030 Mask 4'b0101, strobes ch0/ch2 = (A0,B0),(A1,B1) -> one word {B1,A1,B0,A0} after 2nd strobe, sync=1.
REQ-031 Mask 4'b0111, 4 strobes (12 lanes) -> exactly 3 words; count returns to 0; lane order verified.
REQ-032 pack_ready=0, mask 1111, 5 strobes, FIFO_DEPTH=4 -> 4 words held, adc_dovf one-cycle pulse on 5th; later read gives words 1-4 only.
REQ-033 Mask 0111 change to 0011 after 1 strobe (3 lanes pending) -> pending lanes discarded; next word holds only new-mask samples, sync=1.
REQ-034 adc_rstn=0 for 1 cycle with 2 words queued -> pack_valid=0 next cycle; next emitted word sync=1.
